// File: rtl/subinst_rr_arbiter_if.sv
// Request/grant bundle between the round-robin arbiter and its sibling sub-instances.
// The arbiter uses the master view; a requester uses the slave view.
interface subinst_rr_arbiter_if #(
    parameter int N_REQ = 5,
    parameter int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
);
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] done;
    logic [N_REQ-1:0] gnt;
    logic             gnt_valid;
    logic [ID_W-1:0]  gnt_id;
    logic             timeout_err;
    logic             busy;

    modport master (
        input  req,
        input  done,
        output gnt,
        output gnt_valid,
        output gnt_id,
        output timeout_err,
        output busy
    );

    modport slave (
        output req,
        output done,
        input  gnt,
        input  gnt_valid,
        input  gnt_id,
        input  timeout_err,
        input  busy
    );
endinterface

// File: rtl/subinst_rr_arbiter.sv
// Round-robin arbiter that hands one shared resource to sibling sub-instances.
// Grants are one-hot and registered, and a watchdog reclaims a grant that is held too long.
module subinst_rr_arbiter #(
    parameter int N_REQ   = 5,
    parameter int TIMEOUT = 255,
    parameter int ID_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    subinst_rr_arbiter_if.master bus
);
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [ID_W-1:0]    ptr_reg, ptr_next;
    logic [TMR_W-1:0]   timer_reg, timer_next;
    logic [N_REQ-1:0]   gnt_reg, gnt_next;
    logic [ID_W-1:0]    gnt_id_reg, gnt_id_next;
    logic               tout_reg, tout_next;

    // Candidate gi is the requester gi positions after the round-robin pointer.
    logic [ID_W-1:0]    cand_idx [N_REQ];
    logic [N_REQ-1:0]   cand_req;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
        logic [ID_W:0] sum;
        assign sum           = {1'b0, ptr_reg} + (ID_W+1)'(gi);
        assign cand_idx[gi]  = (sum >= (ID_W+1)'(N_REQ)) ? ID_W'(sum - (ID_W+1)'(N_REQ))
                                                         : sum[ID_W-1:0];
        assign cand_req[gi]  = bus.req[cand_idx[gi]];
    end

    logic [ID_W-1:0] sel_idx;
    logic            sel_found;

    always_comb begin
        sel_idx   = '0;
        sel_found = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (cand_req[k]) begin
                sel_idx   = cand_idx[k];
                sel_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_next  = state_reg;
        ptr_next    = ptr_reg;
        timer_next  = timer_reg;
        gnt_next    = gnt_reg;
        gnt_id_next = gnt_id_reg;
        tout_next   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (sel_found) begin
                    gnt_next    = N_REQ'(1) << sel_idx;
                    gnt_id_next = sel_idx;
                    timer_next  = '0;
                    state_next  = GRANT;
                end
            end
            GRANT: begin
                // done beats withdrawal, which beats the watchdog.
                if (bus.done[gnt_id_reg] || !bus.req[gnt_id_reg]
                    || timer_reg == TMR_W'(TIMEOUT - 1)) begin
                    tout_next  = !bus.done[gnt_id_reg] && bus.req[gnt_id_reg];
                    gnt_next   = '0;
                    state_next = RELEASE;
                    ptr_next   = (gnt_id_reg == ID_W'(N_REQ - 1)) ? '0 : gnt_id_reg + 1'b1;
                end else if (timer_reg != {TMR_W{1'b1}}) begin
                    timer_next = timer_reg + 1'b1;
                end
            end
            RELEASE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            ptr_reg    <= '0;
            timer_reg  <= '0;
            gnt_reg    <= '0;
            gnt_id_reg <= '0;
            tout_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            ptr_reg    <= ptr_next;
            timer_reg  <= timer_next;
            gnt_reg    <= gnt_next;
            gnt_id_reg <= gnt_id_next;
            tout_reg   <= tout_next;
        end
    end

    assign bus.gnt         = gnt_reg;
    assign bus.gnt_valid   = |gnt_reg;
    assign bus.gnt_id      = gnt_id_reg;
    assign bus.timeout_err = tout_reg;
    assign bus.busy        = (state_reg != IDLE);
endmodule

// File: tb/tb_subinst_rr_arbiter.sv
// Bench for subinst_rr_arbiter: directed vector table, hand sequences for multi-cycle
// corners, then random traffic compared against a cycle-count reference model.
module tb_subinst_rr_arbiter;
    localparam int N  = 5;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    subinst_rr_arbiter_if #(.N_REQ(N)) bus ();
    subinst_rr_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [N-1:0] req;
        logic [N-1:0] done;
        logic [N-1:0] gnt;
        int           id;
        bit           terr;
        bit           busy;
    } vec_t;
    vec_t vecs[$];

    // Reference model: who owns the resource, for how many cycles, and the rotation start.
    int m_owner, m_held, m_cool, m_ptr, m_last;
    bit m_terr;

    function automatic void model_reset();
        m_owner = -1; m_held = 0; m_cool = 0; m_ptr = 0; m_last = 0; m_terr = 0;
    endfunction

    function automatic void model_step(logic [N-1:0] r, logic [N-1:0] d);
        m_terr = 0;
        if (m_owner >= 0) begin
            if (d[m_owner] || !r[m_owner] || m_held == TO) begin
                m_terr  = !d[m_owner] && r[m_owner];
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
                m_cool  = 1;
            end else begin
                m_held++;
            end
        end else if (m_cool != 0) begin
            m_cool = 0;
        end else begin
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (m_ptr + k) % N;
                if (r[idx] && m_owner < 0) begin
                    m_owner = idx;
                    m_last  = idx;
                    m_held  = 1;
                end
            end
        end
    endfunction

    function automatic void add(logic [N-1:0] r, logic [N-1:0] d, logic [N-1:0] g,
                                int id, bit t, bit b);
        vec_t v;
        v.req = r; v.done = d; v.gnt = g; v.id = id; v.terr = t; v.busy = b;
        vecs.push_back(v);
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(string tag, logic [N-1:0] eg, int eid, bit et, bit eb);
        chk({tag, " gnt"}, int'(bus.gnt), int'(eg));
        chk({tag, " gnt_valid"}, int'(bus.gnt_valid), int'(|eg));
        chk({tag, " gnt_id"}, int'(bus.gnt_id), eid);
        chk({tag, " timeout_err"}, int'(bus.timeout_err), int'(et));
        chk({tag, " busy"}, int'(bus.busy), int'(eb));
        chk({tag, " onehot"}, ($countones(bus.gnt) <= 1) ? 1 : 0, 1);
    endtask

    task automatic apply(logic [N-1:0] r, logic [N-1:0] d);
        bus.req  = r;
        bus.done = d;
        @(posedge clk);
        #1;
        model_step(r, d);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        bus.req  = '0;
        bus.done = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", '0, 0, 0, 0);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic [N-1:0] r, d, onehot, eg;
        int gap, prev_owner;

        bus.req  = '0;
        bus.done = '0;
        model_reset();

        // Directed table: inputs for one cycle, then outputs expected after the edge.
        add(5'b00100, 5'b00000, 5'b00100, 2, 0, 1);
        add(5'b00100, 5'b00000, 5'b00100, 2, 0, 1);
        add(5'b00100, 5'b00000, 5'b00100, 2, 0, 1);
        add(5'b00100, 5'b00100, 5'b00000, 2, 0, 1);
        add(5'b00000, 5'b00000, 5'b00000, 2, 0, 0);
        for (int i = 0; i < TO; i++) add(5'b01000, 5'b00000, 5'b01000, 3, 0, 1);
        add(5'b01000, 5'b00000, 5'b00000, 3, 1, 1);
        add(5'b11001, 5'b00000, 5'b00000, 3, 0, 0);
        add(5'b11001, 5'b00000, 5'b10000, 4, 0, 1);
        add(5'b11001, 5'b10000, 5'b00000, 4, 0, 1);
        add(5'b00010, 5'b00000, 5'b00000, 4, 0, 0);
        add(5'b00010, 5'b00000, 5'b00010, 1, 0, 1);
        add(5'b00110, 5'b00001, 5'b00010, 1, 0, 1);
        add(5'b11001, 5'b00000, 5'b00000, 1, 0, 1);
        add(5'b11001, 5'b00000, 5'b00000, 1, 0, 0);
        add(5'b11001, 5'b00000, 5'b01000, 3, 0, 1);
        for (int i = 1; i < TO; i++) add(5'b01000, 5'b00000, 5'b01000, 3, 0, 1);
        add(5'b01000, 5'b01000, 5'b00000, 3, 0, 1);
        add(5'b00000, 5'b00000, 5'b00000, 3, 0, 0);

        do_reset();
        foreach (vecs[i]) begin
            apply(vecs[i].req, vecs[i].done);
            $display("vec %0d req=%b done=%b gnt=%b id=%0d terr=%0d busy=%0d",
                     i, vecs[i].req, vecs[i].done, bus.gnt, bus.gnt_id,
                     bus.timeout_err, bus.busy);
            chk_all($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].id,
                    vecs[i].terr, vecs[i].busy);
        end

        // Full contention: strict rotation with two idle cycles between grants.
        do_reset();
        apply('1, '0);
        for (int g = 0; g < 6; g++) begin
            onehot = N'(1) << (g % N);
            chk($sformatf("contend%0d gnt_id", g), int'(bus.gnt_id), g % N);
            chk($sformatf("contend%0d gnt", g), int'(bus.gnt), int'(onehot));
            $display("contend grant %0d -> id %0d gnt=%b", g, bus.gnt_id, bus.gnt);
            repeat (3) apply('1, '0);
            chk($sformatf("contend%0d held", g), int'(bus.gnt), int'(onehot));
            apply('1, onehot);
            chk($sformatf("contend%0d released", g), int'(bus.gnt), 0);
            gap = 1;
            if (g < 5) begin
                for (int w = 0; w < 10; w++) begin
                    apply('1, '0);
                    if (bus.gnt_valid) break;
                    gap++;
                end
                chk($sformatf("contend%0d gap", g), gap, 2);
            end
        end

        // Asynchronous reset in the middle of a grant.
        do_reset();
        apply(5'b10000, '0);
        chk("pre-rst gnt", int'(bus.gnt), 5'b10000);
        #2 rst = 1'b1;
        #1;
        $display("async reset mid-grant gnt=%b busy=%0d", bus.gnt, bus.busy);
        chk_all("async rst", '0, 0, 0, 0);
        model_reset();
        #1 rst = 1'b0;
        apply(5'b10001, '0);
        chk_all("post-rst", 5'b00001, 0, 0, 1);

        // Random traffic against the reference model.
        do_reset();
        r = '0;
        for (int c = 0; c < 600; c++) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(0, 7) == 0) r[b] = ~r[b];
            d = '0;
            if (m_owner >= 0 && $urandom_range(0, 5) == 0) d[m_owner] = 1'b1;
            if ($urandom_range(0, 9) == 0) d[$urandom_range(0, N - 1)] = 1'b1;
            prev_owner = m_owner;
            apply(r, d);
            eg = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
            chk_all($sformatf("rand c%0d", c), eg, m_last, m_terr,
                    (m_owner >= 0) || (m_cool != 0));
            if (m_owner >= 0 && prev_owner < 0)
                $display("rand c%0d grant id=%0d req=%b", c, m_owner, r);
            if (m_terr)
                $display("rand c%0d watchdog release id=%0d", c, m_last);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
